image_loader: RTL and testbench
===============================

Name: image_loader

Overview:
- Upstream neighbour of the `inference` block: receives an MNIST image as a raw byte stream from the UART receiver and stores it in a ping-pong pixel buffer.
- Serves the pixels to `inference` via its `input_addr` / `input_pixel` read port.
- Launches inference with a `start_inference` pulse once a complete frame is present and the weights are loaded.
- Ping-pong buffering lets the next image stream in while the current one is being classified.

Parameters:
NUM_PIXELS, 784, pixels per frame (28x28)
ADDR_W, 10, pixel address width
IDLE_TIMEOUT, 1000000, idle clocks inside a partial frame before the frame is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
weights_ready  in  1  weight/bias memories loaded
inference_done  in  1  one-cycle pulse from inference, read bank released
input_addr  in  ADDR_W  pixel read address from inference
input_pixel  out  8  registered pixel read data
start_inference  out  1  one-cycle launch pulse to inference
image_ready  out  1  read bank locked/in use by inference
frame_error  out  1  one-cycle pulse, frame discarded
overrun  out  1  one-cycle pulse, byte dropped
byte_count  out  ADDR_W  bytes stored in current write frame

Behaviour:
- Reset: all outputs 0; wr_ptr=0; wr_bank=0, rd_bank=1; read lock clear; timeout counter 0; state RECV. Memory contents undefined.
- Read port:
  - input_pixel <= bank[rd_bank][input_addr] every cycle, 1-cycle latency, no enable.
  - input_addr >= NUM_PIXELS returns 0.
- State RECV:
  - On rx_valid, write rx_data to bank[wr_bank][wr_ptr], increment wr_ptr, clear timeout counter.
  - The write that makes wr_ptr == NUM_PIXELS moves to PENDING.
  - byte_count = wr_ptr.
- Timeout:
  - In RECV with wr_ptr > 0 and no rx_valid, the timeout counter increments.
  - When it reaches IDLE_TIMEOUT: pulse frame_error, set wr_ptr=0, clear the counter.
  - The counter is idle while wr_ptr == 0.
- State PENDING:
  - Swap when the read lock is clear and weights_ready=1: exchange wr_bank and rd_bank, set the read lock, pulse start_inference for one cycle, set wr_ptr=0, return to RECV.
  - rx_valid while in PENDING: byte dropped, overrun pulses.
- Read lock:
  - Cleared by inference_done.
  - A swap requires the lock to be clear at the start of the cycle, so inference_done and a pending swap in the same cycle give a swap exactly 1 cycle later.
  - image_ready mirrors the lock.
- The write bank is never the bank being read; a locked read bank is never written.
- start_inference latency: asserted in the cycle after the clock edge that writes the last pixel, provided the lock is clear and weights_ready=1.
- Spurious inference_done with the lock clear: ignored.
- Reset mid-frame or mid-inference: immediate return to the reset state; partial frame lost.

Optional Feature:
- Macro: IMAGE_CHECKSUM_EN.
- Defined:
  - After the last pixel, the FSM enters CHECK and awaits one extra byte.
  - That byte must equal the 8-bit sum mod 256 of all NUM_PIXELS pixels, accumulated during RECV and cleared at frame start.
  - Match: go to PENDING.
  - Mismatch: frame_error pulse, wr_ptr=0, return to RECV with no swap.
  - The timeout also applies in CHECK.
- Undefined: no CHECK state, no accumulator; the frame is complete after NUM_PIXELS bytes.

Test Plan:
- Send 784 bytes (value = i mod 256) with weights_ready=1 -> exactly one start_inference pulse in the cycle after the 784th byte is written, image_ready=1; input_addr=5 gives 5 next cycle; addr=300 gives 44; addr=800 gives 0.
- Full frame with weights_ready=0 -> no start, byte_count holds 784 in PENDING; raise weights_ready -> start pulse on the next cycle.
- Frame A locked, stream frame B (all 0xAA) plus 3 extra bytes -> 3 overrun pulses; reads still return frame A values; pulse inference_done -> start 1 cycle later, reads return 0xAA.
- IDLE_TIMEOUT=50: send 100 bytes, then idle 50 clocks -> one frame_error pulse, byte_count=0; a subsequent full frame starts normally.
- Assert rst at byte 400 while inference is locked -> all outputs 0, byte_count=0, image_ready=0; a new 784-byte frame starts immediately.
- IMAGE_CHECKSUM_EN, pixels all 0x01:
  - Checksum 0x10 -> start pulse.
  - Checksum 0x11 -> frame_error pulse, no start, byte_count=0.

Source files
------------

// File: rtl/image_loader_if.sv
// image_loader bus: UART byte input, inference read port and status.
// The loader connects through the slave modport.
interface image_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              weights_ready;
   logic              inference_done;
   logic [ADDR_W-1:0] input_addr;
   logic [7:0]        input_pixel;
   logic              start_inference;
   logic              image_ready;
   logic              frame_error;
   logic              overrun;
   logic [ADDR_W-1:0] byte_count;

   modport master (
      output rx_data, rx_valid, weights_ready,
      output inference_done, input_addr,
      input  input_pixel, start_inference, image_ready,
      input  frame_error, overrun, byte_count
   );

   modport slave (
      input  rx_data, rx_valid, weights_ready,
      input  inference_done, input_addr,
      output input_pixel, start_inference, image_ready,
      output frame_error, overrun, byte_count
   );
endinterface

// File: rtl/image_loader.sv
// Ping-pong MNIST frame loader in front of the inference engine.
// Optional macro IMAGE_CHECKSUM_EN adds a trailing checksum byte per frame.
module image_loader #(
   parameter int NUM_PIXELS   = 784,
   parameter int ADDR_W       = 10,
   parameter int IDLE_TIMEOUT = 1000000
) (
   input logic           clk,
   input logic           rst,
   image_loader_if.slave bus
);

   localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);

`ifdef IMAGE_CHECKSUM_EN
   typedef enum logic [1:0] {RECV, PENDING, CHECK} state_t;
`else
   typedef enum logic [1:0] {RECV, PENDING} state_t;
`endif

   state_t            state_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic              wr_bank_q;
   logic              rd_bank_q;
   logic              lock_q;
   logic [TO_W-1:0]   tmo_q;
   logic              start_q;
   logic              err_q;
   logic              ovr_q;
   logic [7:0]        pix_q;
   logic [7:0]        pix_d;
`ifdef IMAGE_CHECKSUM_EN
   logic [7:0]        sum_q;
`endif

   logic [7:0] mem [2][NUM_PIXELS];

   logic wr_en;
   logic last_wr;
   logic can_swap;
   logic swap_now;
   logic tmo_hit;

   // Decode write, frame-complete and swap conditions
   always_comb begin
      wr_en    = (state_q == RECV) && bus.rx_valid;
      last_wr  = wr_en &&
                 (wr_ptr_q == ADDR_W'(NUM_PIXELS - 1));
      can_swap = !lock_q && bus.weights_ready;
      tmo_hit  = (tmo_q == TO_W'(IDLE_TIMEOUT - 1));
      swap_now = can_swap && (state_q == PENDING);
`ifndef IMAGE_CHECKSUM_EN
      // Complete frame with a free reader launches on the same edge
      if (can_swap && last_wr)
         swap_now = 1'b1;
`endif
   end

   // Store incoming bytes into the write bank
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_bank_q][wr_ptr_q] <= bus.rx_data;
   end

   // Out-of-range read addresses return zero
   always_comb begin
      pix_d = '0;
      if (bus.input_addr < ADDR_W'(NUM_PIXELS))
         pix_d = mem[rd_bank_q][bus.input_addr];
   end

   // Registered pixel read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pix_q <= '0;
      else
         pix_q <= pix_d;
   end

   // Frame FSM, bank swap, read lock, timeout and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RECV;
         wr_ptr_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b1;
         lock_q    <= 1'b0;
         tmo_q     <= '0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef IMAGE_CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         start_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;

         if (bus.inference_done)
            lock_q <= 1'b0;

         unique case (state_q)
            RECV: begin
               if (bus.rx_valid) begin
                  wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                  tmo_q    <= '0;
`ifdef IMAGE_CHECKSUM_EN
                  sum_q    <= sum_q + bus.rx_data;
                  if (last_wr)
                     state_q <= CHECK;
`else
                  if (last_wr)
                     state_q <= PENDING;
`endif
               end else if (wr_ptr_q != '0) begin
                  if (tmo_hit) begin
                     err_q    <= 1'b1;
                     wr_ptr_q <= '0;
                     tmo_q    <= '0;
`ifdef IMAGE_CHECKSUM_EN
                     sum_q    <= '0;
`endif
                  end else begin
                     tmo_q <= tmo_q + TO_W'(1);
                  end
               end
            end
`ifdef IMAGE_CHECKSUM_EN
            CHECK: begin
               if (bus.rx_valid) begin
                  tmo_q <= '0;
                  if (bus.rx_data == sum_q) begin
                     state_q <= PENDING;
                  end else begin
                     err_q    <= 1'b1;
                     wr_ptr_q <= '0;
                     sum_q    <= '0;
                     state_q  <= RECV;
                  end
               end else if (tmo_hit) begin
                  err_q    <= 1'b1;
                  wr_ptr_q <= '0;
                  tmo_q    <= '0;
                  sum_q    <= '0;
                  state_q  <= RECV;
               end else begin
                  tmo_q <= tmo_q + TO_W'(1);
               end
            end
`endif
            PENDING: begin
               if (bus.rx_valid)
                  ovr_q <= 1'b1;
            end
            default: state_q <= RECV;
         endcase

         // Swap overrides the per-state pointer update
         if (swap_now) begin
            wr_bank_q <= rd_bank_q;
            rd_bank_q <= wr_bank_q;
            lock_q    <= 1'b1;
            start_q   <= 1'b1;
            wr_ptr_q  <= '0;
            tmo_q     <= '0;
            state_q   <= RECV;
`ifdef IMAGE_CHECKSUM_EN
            sum_q     <= '0;
`endif
         end
      end
   end

   assign bus.input_pixel     = pix_q;
   assign bus.start_inference = start_q;
   assign bus.image_ready     = lock_q;
   assign bus.frame_error     = err_q;
   assign bus.overrun         = ovr_q;
   assign bus.byte_count      = wr_ptr_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a read-data scoreboard.
// Honours IMAGE_CHECKSUM_EN when the design is built with it.
module tb_image_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n_start = 0;
   int   n_err = 0;
   int   n_ovr = 0;
   int   s0, e0, o0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   image_loader_if #(.ADDR_W(10)) bus ();

   image_loader #(
      .NUM_PIXELS(784),
      .ADDR_W(10),
      .IDLE_TIMEOUT(50)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Pulse monitors: count the value held during the previous cycle
   always @(posedge clk) begin
      if (bus.start_inference === 1'b1) n_start++;
      if (bus.frame_error === 1'b1)     n_err++;
      if (bus.overrun === 1'b1)         n_ovr++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drive a read address, expect the pixel one cycle later
   task automatic rd(input string tag,
                     input logic [9:0] a,
                     input logic [7:0] e);
      logic [7:0] x;
      bus.input_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      x = exp_q.pop_front();
      chk(tag, {24'd0, bus.input_pixel}, {24'd0, x});
   endtask

   // One byte per cycle; returns at the negedge after the last write
   task automatic send_frame(input bit ramp,
                             input logic [7:0] v,
                             input bit ck_good);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'd0;
      for (int i = 0; i < 784; i++) begin
         b = ramp ? 8'(i) : v;
         s = s + b;
         bus.rx_data  = b;
         bus.rx_valid = 1'b1;
         @(negedge clk);
      end
`ifdef IMAGE_CHECKSUM_EN
      bus.rx_data  = ck_good ? s : s + 8'd1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      @(negedge clk);
`else
      if (!ck_good) s = s + 8'd1;
`endif
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         bus.rx_data  = 8'(i);
         bus.rx_valid = 1'b1;
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic release_lock();
      bus.inference_done = 1'b1;
      @(negedge clk);
      bus.inference_done = 1'b0;
      chk("lock_release", {31'd0, bus.image_ready}, 32'd0);
   endtask

   initial begin
      bus.rx_data        = '0;
      bus.rx_valid       = 1'b0;
      bus.weights_ready  = 1'b1;
      bus.inference_done = 1'b0;
      bus.input_addr     = '0;

      // Reset state
      cyc(3);
      chk("rst_start", {31'd0, bus.start_inference}, 32'd0);
      chk("rst_ready", {31'd0, bus.image_ready}, 32'd0);
      chk("rst_err", {31'd0, bus.frame_error}, 32'd0);
      chk("rst_ovr", {31'd0, bus.overrun}, 32'd0);
      chk("rst_cnt", {22'd0, bus.byte_count}, 32'd0);
      chk("rst_pix", {24'd0, bus.input_pixel}, 32'd0);
      rst = 1'b0;
      cyc(2);

      // Frame A: ramp, launch right after last write
      s0 = n_start;
      send_frame(1'b1, 8'd0, 1'b1);
      chk("a_start", {31'd0, bus.start_inference}, 32'd1);
      chk("a_ready", {31'd0, bus.image_ready}, 32'd1);
      chk("a_cnt0", {22'd0, bus.byte_count}, 32'd0);
      @(negedge clk);
      chk("a_start_low", {31'd0, bus.start_inference}, 32'd0);
      cyc(2);
      chk("a_one_pulse", n_start - s0, 32'd1);
      rd("a_px5", 10'd5, 8'd5);
      rd("a_px300", 10'd300, 8'd44);
      rd("a_px800", 10'd800, 8'd0);
      rd("a_px783", 10'd783, 8'd15);

      // Frame B (0xAA) while A locked, plus 3 dropped bytes
      s0 = n_start;
      o0 = n_ovr;
      send_frame(1'b0, 8'hAA, 1'b1);
      chk("b_cnt_pend", {22'd0, bus.byte_count}, 32'd784);
      send_bytes(3);
      cyc(2);
      chk("b_overruns", n_ovr - o0, 32'd3);
      chk("b_no_start", n_start - s0, 32'd0);
      chk("b_ready", {31'd0, bus.image_ready}, 32'd1);
      rd("b_px5_old", 10'd5, 8'd5);
      rd("b_px300_old", 10'd300, 8'd44);
      bus.inference_done = 1'b1;
      @(negedge clk);
      bus.inference_done = 1'b0;
      chk("b_start_wait", {31'd0, bus.start_inference}, 32'd0);
      chk("b_unlocked", {31'd0, bus.image_ready}, 32'd0);
      @(negedge clk);
      chk("b_start", {31'd0, bus.start_inference}, 32'd1);
      chk("b_relock", {31'd0, bus.image_ready}, 32'd1);
      rd("b_px5_new", 10'd5, 8'hAA);
      rd("b_px700_new", 10'd700, 8'hAA);

      // Weights not ready holds the frame in PENDING
      release_lock();
      bus.weights_ready = 1'b0;
      s0 = n_start;
      send_frame(1'b1, 8'd0, 1'b1);
      cyc(3);
      chk("w_no_start", n_start - s0, 32'd0);
      chk("w_cnt_hold", {22'd0, bus.byte_count}, 32'd784);
      bus.weights_ready = 1'b1;
      @(negedge clk);
      chk("w_start", {31'd0, bus.start_inference}, 32'd1);
      chk("w_cnt0", {22'd0, bus.byte_count}, 32'd0);
      rd("w_px300", 10'd300, 8'd44);

      // Idle timeout inside a partial frame
      release_lock();
      e0 = n_err;
      send_bytes(100);
      chk("t_cnt100", {22'd0, bus.byte_count}, 32'd100);
      cyc(49);
      chk("t_early_err", {31'd0, bus.frame_error}, 32'd0);
      chk("t_early_cnt", {22'd0, bus.byte_count}, 32'd100);
      @(negedge clk);
      chk("t_err", {31'd0, bus.frame_error}, 32'd1);
      chk("t_cnt0", {22'd0, bus.byte_count}, 32'd0);
      cyc(5);
      chk("t_err_once", n_err - e0, 32'd1);
      s0 = n_start;
      send_frame(1'b1, 8'd0, 1'b1);
      chk("t_restart", {31'd0, bus.start_inference}, 32'd1);
      rd("t_px10", 10'd10, 8'd10);

      // Reset mid-frame while locked
      send_bytes(400);
      chk("r_cnt400", {22'd0, bus.byte_count}, 32'd400);
      rst = 1'b1;
      #1;
      chk("r_ready", {31'd0, bus.image_ready}, 32'd0);
      chk("r_cnt", {22'd0, bus.byte_count}, 32'd0);
      chk("r_start", {31'd0, bus.start_inference}, 32'd0);
      chk("r_pix", {24'd0, bus.input_pixel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_frame(1'b1, 8'd0, 1'b1);
      chk("r_new_start", {31'd0, bus.start_inference}, 32'd1);
      rd("r_px200", 10'd200, 8'd200);

`ifdef IMAGE_CHECKSUM_EN
      // Checksum: all-ones frame sums to 0x10
      release_lock();
      s0 = n_start;
      send_frame(1'b0, 8'h01, 1'b1);
      chk("c_good_start", {31'd0, bus.start_inference}, 32'd1);
      release_lock();
      s0 = n_start;
      e0 = n_err;
      send_frame(1'b0, 8'h01, 1'b0);
      cyc(2);
      chk("c_bad_err", n_err - e0, 32'd1);
      chk("c_bad_nostart", n_start - s0, 32'd0);
      chk("c_bad_cnt", {22'd0, bus.byte_count}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
